// File: rtl/exec_pkg.sv
// exec_pkg: opcodes, FSM state encoding and default widths shared by the exec unit
package exec_pkg;
  localparam int WIDTH_DEF   = 32;
  localparam int RADDR_W_DEF = 3;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2} state_e;
  function automatic logic is_reserved(input logic [2:0] op);
    return op[2] & op[1];
  endfunction
endpackage

// File: rtl/exec_if.sv
// exec_if: issue port and register-file write-back port of the exec unit
interface exec_if import exec_pkg::*; #(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int RADDR_W = RADDR_W_DEF
);
  logic               start;
  logic [2:0]         op;
  logic [RADDR_W-1:0] dest_reg;
  logic [WIDTH-1:0]   src_a;
  logic [WIDTH-1:0]   src_b;
  logic               busy;
  logic [RADDR_W-1:0] write_reg;
  logic [WIDTH-1:0]   write_data;
  logic               reg_write;
  modport master (output start, op, dest_reg, src_a, src_b,
                  input  busy, write_reg, write_data, reg_write);
  modport slave  (input  start, op, dest_reg, src_a, src_b,
                  output busy, write_reg, write_data, reg_write);
endinterface

// File: rtl/mul_seq.sv
// mul_seq: shift-add multiplier datapath, one multiplier bit consumed per step
module mul_seq import exec_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] acc_nxt_o
);
  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
  // exposing the post-step sum lets the final step's result be written directly
  assign acc_nxt_o = acc_q + (mplier_q[0] ? mcand_q : '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (load_i) begin
      acc_q    <= '0;
      mcand_q  <= a_i;
      mplier_q <= b_i;
    end else if (step_i) begin
      acc_q    <= acc_nxt_o;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end
endmodule

// File: rtl/exec_unit.sv
// exec_unit: single-issue ALU with a sequential multiplier and register-file write-back
module exec_unit import exec_pkg::*; #(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int RADDR_W = RADDR_W_DEF
) (
  input logic   clk,
  input logic   rst_n,
  exec_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         op_q;
  logic [RADDR_W-1:0] dest_q, wreg_q;
  logic [WIDTH-1:0]   a_q, b_q, wdata_q, result, mul_acc;
  logic               wen_q, load, step, is_mul, last;
  assign is_mul = op_q == OP_MUL;
  assign last   = cnt_q == CW'(WIDTH - 1);
  assign load   = state_q == S_IDLE && bus.start;
  assign step   = state_q == S_EXEC && is_mul;
  always_comb begin
    state_d = state_q == S_IDLE ? (bus.start ? S_EXEC : S_IDLE) :
              state_q == S_EXEC ? (is_reserved(op_q) ? S_IDLE : (!is_mul || last) ? S_DONE : S_EXEC) :
              S_IDLE;
    cnt_d   = load ? '0 : step ? cnt_q + 1'b1 : cnt_q;
    result  = op_q == OP_ADD ? a_q + b_q :
              op_q == OP_SUB ? a_q - b_q :
              op_q == OP_AND ? a_q & b_q :
              op_q == OP_OR  ? a_q | b_q :
              op_q == OP_SLT ? {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)} :
              mul_acc;
  end
  mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk(clk), .rst_n(rst_n), .load_i(load), .step_i(step),
    .a_i(bus.src_a), .b_i(bus.src_b), .acc_nxt_o(mul_acc)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      dest_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      wdata_q <= '0;
      wreg_q  <= '0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        op_q   <= bus.op;
        dest_q <= bus.dest_reg;
        a_q    <= bus.src_a;
        b_q    <= bus.src_b;
      end
      // write port is registered so it is valid for the whole DONE cycle
      if (state_d == S_DONE) begin
        wdata_q <= result;
        wreg_q  <= dest_q;
      end
      wen_q <= state_d == S_DONE;
    end
  end
  assign bus.busy       = state_q != S_IDLE;
  assign bus.reg_write  = wen_q;
  assign bus.write_data = wdata_q;
  assign bus.write_reg  = wreg_q;
endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the operand and result width in bits.
REQ-002 The block SHALL have parameter RADDR_W, default 3, meaning the register address width (8 registers).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to execute one operation.
REQ-006 The block SHALL have port op, input, 3 bits: operation code.
REQ-007 The block SHALL have port dest_reg, input, RADDR_W bits: destination register index.
REQ-008 The block SHALL have ports src_a and src_b, input, WIDTH bits each: operands taken from the register file read ports.
REQ-009 The block SHALL have port busy, output, 1 bit: high while an accepted operation is outstanding.
REQ-010 The block SHALL have port write_reg, output, RADDR_W bits: register file write address.
REQ-011 The block SHALL have port write_data, output, WIDTH bits: register file write data.
REQ-012 The block SHALL have port reg_write, output, 1 bit: register file write enable, one-cycle pulse.

Function
REQ-013 The block SHALL implement the states IDLE, EXEC and DONE, and busy SHALL be high in every state except IDLE.
REQ-014 In IDLE with start=1 at a rising edge, the block SHALL capture op, dest_reg, src_a and src_b, clear the iteration counter and enter EXEC.
REQ-015 The block SHALL ignore start whenever busy=1, with no effect on state or captured operands.
REQ-016 The opcodes SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT (signed; result 1 or 0), 101 MUL, 110 and 111 reserved.
REQ-017 ADD, SUB and MUL SHALL return the low WIDTH bits, wrapping modulo 2^WIDTH with no overflow flag.
REQ-018 ADD, SUB, AND, OR and SLT SHALL complete on the first EXEC edge (entry at edge k, DONE at edge k+1).
REQ-019 MUL SHALL use a shift-add algorithm, one multiplier bit per EXEC edge, counter 0..WIDTH-1.
REQ-020 MUL SHALL enter DONE on the edge where the counter reaches WIDTH-1 (entry at edge k, DONE at edge k+WIDTH).
REQ-021 Reserved opcodes SHALL go from EXEC to IDLE after one edge without asserting reg_write.
REQ-022 In DONE, reg_write SHALL be 1 for exactly one cycle, with write_reg = captured dest_reg and write_data = result, all registered outputs.
REQ-023 DONE SHALL return to IDLE on the next edge; a new start SHALL be accepted at the earliest on the edge after that return.
REQ-024 Outside DONE, reg_write SHALL be 0, and write_data and write_reg SHALL hold their last values.

Reset
REQ-025 When rst_n=0, the block SHALL immediately force state to IDLE and set busy, reg_write, write_reg, write_data, the counter and the captured operands to 0.
REQ-026 A reset during EXEC or DONE SHALL abort the operation, with no reg_write pulse after rst_n is released.
REQ-027 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-028 The package exec_pkg SHALL hold the opcode constants, the state encoding and the WIDTH/RADDR_W defaults.
REQ-029 The MUL datapath SHALL be a sub-module mul_seq, which holds the accumulator, shifted multiplicand and multiplier registers and takes load/step controls from the exec_unit FSM.

Verification
REQ-030 ADD: src_a=5, src_b=7, dest_reg=3 -> reg_write=1 for one cycle after edge k+1, write_data=12, write_reg=3.
REQ-031 SUB then SLT: SUB 0-1 -> write_data=0xFFFFFFFF; SLT with src_a=0xFFFFFFFF, src_b=1 -> write_data=1.
REQ-032 MUL: src_a=0x0000FFFF, src_b=0x00010001 -> write_data=0xFFFFFFFF exactly after edge k+32; busy high for 33 cycles.
REQ-033 Busy handling: start pulses with different operands during a MUL -> ignored; only the original result is written, once.
REQ-034 Reset abort: rst_n=0 at MUL iteration 10 -> busy=0 and reg_write=0 immediately, and no write follows after release.
REQ-035 Reserved op=110 -> no reg_write, busy high for exactly one cycle, and a following ADD is accepted normally.
